// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic array
// and its input/output feeders.
package systolic_pkg;

   localparam int DEF_DIM    = 8;
   localparam int DEF_BITS_C = 24;

   typedef logic signed [DEF_BITS_C-1:0] c_elem_t;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DRAIN
   } drain_state_t;

endpackage

// File: rtl/skew_delay.sv
// En-gated shift register used to undo the column skew.
// A depth of zero collapses to a plain wire.
module skew_delay #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      logic unused;
      assign unused = ^{clk, rst_n, en};
      assign q = d;
   end else begin : g_shift
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
               sr[i] <= '0;
         end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++)
               sr[i] <= sr[i-1];
         end
      end

      assign q = sr[DEPTH-1];
   end

endmodule

// File: rtl/memc_deskew.sv
// Re-aligns the skewed result columns of the systolic array
// and streams whole rows of C out over valid/ready.
module memc_deskew
   import systolic_pkg::*;
#(
   parameter int DIM    = DEF_DIM,
   parameter int BITS_C = DEF_BITS_C
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         start,
   input  logic [DIM-1:0][BITS_C-1:0]   Cin,
   output logic                         row_valid,
   input  logic                         row_ready,
   output logic [DIM-1:0][BITS_C-1:0]   row_out,
   output logic [$clog2(DIM)-1:0]       row_idx,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int CW = $clog2(2*DIM);
   localparam int IW = $clog2(DIM);
   localparam logic [CW-1:0] FIRST    = CW'(DIM-1);
   localparam logic [CW-1:0] LAST     = CW'(2*DIM-2);
   localparam logic [CW-1:0] LAST_ROW = CW'(DIM-1);

   drain_state_t state, state_nx;

   logic [DIM-1:0][BITS_C-1:0] aligned;
   logic [DIM-1:0][BITS_C-1:0] rows [DIM];
   logic [CW-1:0] cnt, cur, wr_off;
   logic [CW-1:0] wr_cnt, rd_ptr;
   logic          launch, wr, rd, last_rd;

   for (genvar j = 0; j < DIM; j++) begin : g_col
      skew_delay #(
         .DEPTH (DIM-1-j),
         .WIDTH (BITS_C)
      ) u_dly (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .d     (Cin[j]),
         .q     (aligned[j])
      );
   end

   // cnt lags the en-cycle index by one; cur is the index itself
   assign cur     = cnt + CW'(1);
   assign wr_off  = cur - FIRST;
   assign launch  = start & en;
   assign wr      = (state == CAPTURE) && en &&
                    (cur >= FIRST) && (cur <= LAST);
   assign rd      = row_valid && row_ready;
   assign last_rd = rd && (rd_ptr == LAST_ROW);

   assign row_valid = rd_ptr < wr_cnt;
   assign row_idx   = rd_ptr[IW-1:0];
   assign row_out   = rows[rd_ptr[IW-1:0]];
   assign busy      = state != IDLE;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (launch) state_nx = CAPTURE;
         CAPTURE: if (wr && cur == LAST)
                     state_nx = last_rd ? IDLE : DRAIN;
         DRAIN:   if (last_rd) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         wr_cnt <= '0;
         rd_ptr <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= last_rd;
         if (launch && state != IDLE)
            err <= 1'b1;
         if (launch && state == IDLE) begin
            cnt    <= '0;
            wr_cnt <= '0;
            rd_ptr <= '0;
         end else begin
            if (state == CAPTURE && en)
               cnt <= cur;
            if (wr)
               wr_cnt <= wr_cnt + CW'(1);
            if (rd)
               rd_ptr <= rd_ptr + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIM; i++)
            rows[i] <= '0;
      end else if (wr) begin
         rows[wr_off[IW-1:0]] <= aligned;
      end
   end

endmodule
